nanorv32_wb_buffer: RTL and testbench
=====================================

Name: nanorv32_wb_buffer

Overview:
- Writeback stage directly downstream of the ALU/mul/div stage.
- Captures `alu_res` and its destination register into a 2-entry in-order buffer, then drains it to the register-file write port under a valid/ready handshake.
- Compares pending entries against the current rs1/rs2 so the operand stage can bypass or stall.
- Absorbs register-file port contention (e.g. a load sharing the write port) without stalling the ALU unless the buffer is full.

Parameters:
- DATA_W, 32, result width; matches NANORV32_DATA_MSB+1.
- RADDR_W, 5, register index width.
- DEPTH, 2, buffer entries; only 2 is supported, legal range is 2 only.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- ex_valid  input  1  ALU stage has a result this cycle.
- ex_is_div  input  1  current op is DIV/DIVU/REM/REMU.
- div_ready  input  1  divider result valid; qualifies ex_valid when ex_is_div=1.
- ex_res  input  DATA_W  ALU result.
- ex_rd  input  RADDR_W  destination register.
- ex_we  input  1  instruction writes rd.
- ex_ready  output  1  buffer can accept.
- rf_wr_en  output  1  write request to register file.
- rf_wr_addr  output  RADDR_W  write address.
- rf_wr_data  output  DATA_W  write data.
- rf_wr_ready  input  1  register file accepted write.
- rs1_addr  input  RADDR_W  operand-stage source 1.
- rs2_addr  input  RADDR_W  operand-stage source 2.
- fwd1_hit  output  1  rs1 is pending in buffer.
- fwd1_data  output  DATA_W  youngest pending value for rs1.
- fwd2_hit  output  1  rs2 is pending in buffer.
- fwd2_data  output  DATA_W  youngest pending value for rs2.
- raw_stall  output  1  operand stage must stall.
- buf_count  output  2  occupancy 0..2.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n. On reset, count=0, read/write pointers=0, all entry valid bits=0.
  - Reset values: ex_ready=1, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, fwd*_hit=0, fwd*_data=0, raw_stall=0, buf_count=0.
  - Reset mid-operation discards all pending entries.
- Push: push = ex_valid & (~ex_is_div | div_ready) & ex_ready. Entry {res, rd, we'} is written at the write pointer, where we' = ex_we & (ex_rd != 0). The pointer wraps 1→0.
- ex_ready = (count < 2), registered-state only. There is no combinational path from rf_wr_ready; when full, push is refused even if a pop happens the same cycle.
- Head drain:
  - rf_wr_en = head_valid & head_we; rf_wr_addr/rf_wr_data come from the head entry and are 0 when no head.
  - pop = head_valid & (~head_we | rf_wr_ready).
  - A non-writing entry retires in 1 cycle without asserting rf_wr_en.
- Latency: a pushed result appears on rf_wr_* in the cycle after the push when the buffer was empty. There is no same-cycle flow-through.
- Count update: simultaneous push and pop keeps count unchanged; push only gives count+1; pop only gives count−1. Overflow and underflow are impossible by construction; assert in simulation.
- rf_wr_en stays asserted with stable addr/data until rf_wr_ready=1. rf_wr_ready is ignored while rf_wr_en=0.
- Forwarding match for rsN:
  - Match condition: entry valid & entry we' & entry rd == rsN & rsN != 0.
  - If both entries match, the younger (non-head) wins.
  - fwdN_data=0 when fwdN_hit=0.
  - Forwarding is purely combinational from buffer state; an entry pushed this cycle is not visible until the next cycle.
- raw_stall: defined under Optional Feature.

Optional Feature:
- Macro NANORV32_WB_FWD_EN.
- Defined: fwd*_hit/fwd*_data behave as above and raw_stall=0 always.
- Undefined: fwd*_hit=0 and fwd*_data=0 always; raw_stall = (any entry matches rs1) | (any entry matches rs2), using the same match rule.

Decomposition:
- Package nanorv32_wb_pkg holds DATA_W, RADDR_W, DEPTH defaults, and the entry struct/typedef {data, rd, we}.
- Sub-module nanorv32_wb_match, instantiated twice (rs1, rs2), takes entries plus head pointer and produces hit, data and any-match.

Test Plan:
- Reset then idle: ex_ready=1, buf_count=0, rf_wr_en=0, all forwarding outputs 0.
- Single push, ex_res=0x12345678, rd=5, we=1, rf_wr_ready=1 → next cycle rf_wr_en=1, addr=5, data=0x12345678; retires one cycle later; buf_count goes 1 then 0.
- Backpressure: rf_wr_ready=0, push rd=3 then rd=4 → buf_count=2, ex_ready=0, third push refused. Then set rf_wr_ready=1 → writes 3 then 4 in order, ex_ready=1 the cycle after the first pop.
- Forwarding (FWD_EN): two pending writes to rd=7 with values 0xA then 0xB, rs1=7 → fwd1_hit=1, fwd1_data=0xB. With rs2=0 → fwd2_hit=0.
- Div qualification: ex_is_div=1, ex_valid=1, div_ready=0 for 33 cycles → no push. div_ready=1 with res=0xFFFFFFFF, rd=9 → one push.
- rd=0 with ex_we=1 → no rf_wr_en, entry retires in 1 cycle. Without FWD_EN, a pending rd=6 with rs2=6 gives raw_stall=1.

Source files
------------

// File: rtl/nanorv32_wb_pkg.sv
// nanorv32 writeback buffer: shared widths, entry layout and small helpers.
// Widths are configured here; the buffer depth is fixed at 2 entries.
package nanorv32_wb_pkg;

  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;
  localparam int DEPTH   = 2;
  localparam int PTR_W   = 1;

  // One pending result; we is already qualified so rd=x0 never writes
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [RADDR_W-1:0] rd;
    logic               we;
  } wb_entry_t;

  // Pointer increment; with a 1-bit pointer this wraps 1 -> 0
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return p + 1'b1;
  endfunction

  // An entry supplies rs when it is live, writes, targets rs and rs is not x0
  function automatic logic entry_matches(input wb_entry_t e, input logic v,
                                         input logic [RADDR_W-1:0] rs);
    return v & e.we & (e.rd == rs) & (rs != '0);
  endfunction

endpackage

// File: rtl/nanorv32_wb_buffer_if.sv
// nanorv32 writeback buffer bus: ALU-side result handshake and
// register-file write port. The buffer connects through the slave modport.
interface nanorv32_wb_buffer_if;
  import nanorv32_wb_pkg::*;

  logic               ex_valid;
  logic               ex_is_div;
  logic               div_ready;
  logic [DATA_W-1:0]  ex_res;
  logic [RADDR_W-1:0] ex_rd;
  logic               ex_we;
  logic               ex_ready;

  logic               rf_wr_en;
  logic [RADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0]  rf_wr_data;
  logic               rf_wr_ready;

  modport master (
    output ex_valid, ex_is_div, div_ready, ex_res, ex_rd, ex_we, rf_wr_ready,
    input  ex_ready, rf_wr_en, rf_wr_addr, rf_wr_data
  );

  modport slave (
    input  ex_valid, ex_is_div, div_ready, ex_res, ex_rd, ex_we, rf_wr_ready,
    output ex_ready, rf_wr_en, rf_wr_addr, rf_wr_data
  );

endinterface

// File: rtl/nanorv32_wb_match.sv
// nanorv32 writeback buffer: source-register lookup across the pending
// entries. The non-head entry is the younger one and wins on a double hit.
module nanorv32_wb_match
  import nanorv32_wb_pkg::*;
(
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]      valid,
  input  logic [PTR_W-1:0]      head_ptr,
  input  logic [RADDR_W-1:0]    rs_addr,
  output logic                  hit,
  output logic [DATA_W-1:0]     data,
  output logic                  any_match
);

  logic [PTR_W-1:0] young_ptr;
  logic             head_match;
  logic             young_match;

  assign young_ptr   = ptr_next(head_ptr);
  assign head_match  = entry_matches(entries[head_ptr],  valid[head_ptr],  rs_addr);
  assign young_match = entry_matches(entries[young_ptr], valid[young_ptr], rs_addr);

  // Pick the youngest matching value, zero when nothing matches
  always_comb begin
    hit       = head_match | young_match;
    any_match = head_match | young_match;
    data      = '0;
    if (young_match) begin
      data = entries[young_ptr].data;
    end else if (head_match) begin
      data = entries[head_ptr].data;
    end
  end

endmodule

// File: rtl/nanorv32_wb_buffer.sv
// nanorv32 writeback buffer: 2-entry in-order queue between the ALU stage
// and the register-file write port, with operand-stage hazard lookup.
// Optional macro NANORV32_WB_FWD_EN: when defined, pending values are
// forwarded on fwd*_hit/fwd*_data and raw_stall stays 0; when undefined,
// forwarding outputs are 0 and any pending match raises raw_stall.
module nanorv32_wb_buffer
  import nanorv32_wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  nanorv32_wb_buffer_if.slave bus,
  input  logic [RADDR_W-1:0] rs1_addr,
  input  logic [RADDR_W-1:0] rs2_addr,
  output logic               fwd1_hit,
  output logic [DATA_W-1:0]  fwd1_data,
  output logic               fwd2_hit,
  output logic [DATA_W-1:0]  fwd2_data,
  output logic               raw_stall,
  output logic [1:0]         buf_count
);

`ifdef NANORV32_WB_FWD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [1:0]            count;

  wb_entry_t             head;
  logic                  head_valid;
  logic                  can_accept;
  logic                  push;
  logic                  pop;

  logic                  hit1, hit2, any1, any2;
  logic [DATA_W-1:0]     data1, data2;

  // Acceptance depends only on stored occupancy, so a same-cycle pop
  // never opens a slot for a push when full.
  assign can_accept   = (count < FULL_COUNT);
  assign bus.ex_ready = can_accept;
  assign push = bus.ex_valid & (~bus.ex_is_div | bus.div_ready) & can_accept;

  assign head       = entries[rd_ptr];
  assign head_valid = valid[rd_ptr];
  assign pop        = head_valid & (~head.we | bus.rf_wr_ready);

  assign bus.rf_wr_en   = head_valid & head.we;
  assign bus.rf_wr_addr = head_valid ? head.rd   : '0;
  assign bus.rf_wr_data = head_valid ? head.data : '0;
  assign buf_count      = count;

  // Queue state: drain at the head, fill at the tail, track occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries <= '0;
      valid   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= ptr_next(rd_ptr);
      end
      if (push) begin
        entries[wr_ptr] <= '{data: bus.ex_res,
                             rd:   bus.ex_rd,
                             we:   bus.ex_we & (bus.ex_rd != '0)};
        valid[wr_ptr]   <= 1'b1;
        wr_ptr          <= ptr_next(wr_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  nanorv32_wb_match u_match_rs1 (
    .entries   (entries),
    .valid     (valid),
    .head_ptr  (rd_ptr),
    .rs_addr   (rs1_addr),
    .hit       (hit1),
    .data      (data1),
    .any_match (any1)
  );

  nanorv32_wb_match u_match_rs2 (
    .entries   (entries),
    .valid     (valid),
    .head_ptr  (rd_ptr),
    .rs_addr   (rs2_addr),
    .hit       (hit2),
    .data      (data2),
    .any_match (any2)
  );

  assign fwd1_hit  = FWD_EN & hit1;
  assign fwd1_data = FWD_EN ? data1 : '0;
  assign fwd2_hit  = FWD_EN & hit2;
  assign fwd2_data = FWD_EN ? data2 : '0;
  assign raw_stall = ~FWD_EN & (any1 | any2);

  // Occupancy can never exceed the depth or drop below zero
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push && !pop && count == FULL_COUNT));
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(pop && !push && count == 2'd0));
  assert property (@(posedge clk) disable iff (!rst_n)
                   count == 2'($countones(valid)));

endmodule

// File: tb/tb_nanorv32_wb_buffer.sv
// Testbench for nanorv32_wb_buffer: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_nanorv32_wb_buffer;
  import nanorv32_wb_pkg::*;

`ifdef NANORV32_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nanorv32_wb_buffer_if bus();

  logic [RADDR_W-1:0] rs1_addr, rs2_addr;
  logic               fwd1_hit, fwd2_hit, raw_stall;
  logic [DATA_W-1:0]  fwd1_data, fwd2_data;
  logic [1:0]         buf_count;

  nanorv32_wb_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
    .raw_stall (raw_stall),
    .buf_count (buf_count)
  );

  typedef struct {
    logic [DATA_W-1:0]  data;
    logic [RADDR_W-1:0] rd;
    bit                 we;
  } mentry_t;

  mentry_t mq[$];
  int checks = 0;
  int errors = 0;

  // Youngest pending writer of rs, oldest-to-youngest scan keeps the last hit
  function automatic void model_lookup(input logic [RADDR_W-1:0] rs,
                                       output bit hit, output logic [DATA_W-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (rs != '0) begin
      foreach (mq[i]) begin
        if (mq[i].we && mq[i].rd == rs) begin
          hit  = 1'b1;
          data = mq[i].data;
        end
      end
    end
  endfunction

  task automatic drive_idle();
    bus.ex_valid    = 1'b0;
    bus.ex_is_div   = 1'b0;
    bus.div_ready   = 1'b0;
    bus.ex_res      = '0;
    bus.ex_rd       = '0;
    bus.ex_we       = 1'b0;
    bus.rf_wr_ready = 1'b0;
    rs1_addr        = '0;
    rs2_addr        = '0;
  endtask

  task automatic drive_push(input logic [DATA_W-1:0] res, input logic [RADDR_W-1:0] rd,
                            input logic we);
    bus.ex_valid  = 1'b1;
    bus.ex_is_div = 1'b0;
    bus.ex_res    = res;
    bus.ex_rd     = rd;
    bus.ex_we     = we;
  endtask

  // Advance one clock and apply the same clock to the reference queue
  task automatic tick();
    bit      do_pop, do_push;
    mentry_t e;
    do_pop  = (mq.size() > 0) && (!mq[0].we || bus.rf_wr_ready);
    do_push = bus.ex_valid && (!bus.ex_is_div || bus.div_ready) && (mq.size() < 2);
    e.data  = bus.ex_res;
    e.rd    = bus.ex_rd;
    e.we    = bus.ex_we && (bus.ex_rd != '0);
    @(posedge clk);
    if (do_pop) mq.delete(0);
    if (do_push) mq.push_back(e);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rs1_addr = 5'd3;
    rs2_addr = 5'd17;
    @(negedge clk);
    checks++; if (bus.ex_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ex_ready got %b exp 1", bus.ex_ready); end
    checks++; if (buf_count !== 2'd0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", buf_count); end
    checks++; if (bus.rf_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en got %b exp 0", bus.rf_wr_en); end
    checks++; if (bus.rf_wr_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_wr_addr got %0d exp 0", bus.rf_wr_addr); end
    checks++; if (bus.rf_wr_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_wr_data got %h exp 0", bus.rf_wr_data); end
    checks++; if ({fwd1_hit, fwd2_hit, raw_stall} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b exp 000", {fwd1_hit, fwd2_hit, raw_stall}); end
    checks++; if ({fwd1_data, fwd2_data} !== 64'd0) begin errors++; $display("[TB] FAIL reset_fwd_data got %h exp 0", {fwd1_data, fwd2_data}); end
  endtask

  task automatic test_single_push();
    do_reset();
    bus.rf_wr_ready = 1'b1;
    drive_push(32'h1234_5678, 5'd5, 1'b1);
    @(negedge clk);
    checks++; if (bus.rf_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL single_no_flowthrough got %b exp 0", bus.rf_wr_en); end
    tick();
    bus.ex_valid = 1'b0;
    @(negedge clk);
    checks++; if (buf_count !== 2'd1) begin errors++; $display("[TB] FAIL single_count1 got %0d exp 1", buf_count); end
    checks++; if (bus.rf_wr_en !== 1'b1) begin errors++; $display("[TB] FAIL single_wr_en got %b exp 1", bus.rf_wr_en); end
    checks++; if (bus.rf_wr_addr !== 5'd5) begin errors++; $display("[TB] FAIL single_addr got %0d exp 5", bus.rf_wr_addr); end
    checks++; if (bus.rf_wr_data !== 32'h1234_5678) begin errors++; $display("[TB] FAIL single_data got %h exp 12345678", bus.rf_wr_data); end
    tick();
    @(negedge clk);
    checks++; if (buf_count !== 2'd0) begin errors++; $display("[TB] FAIL single_count0 got %0d exp 0", buf_count); end
    checks++; if (bus.rf_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL single_retired got %b exp 0", bus.rf_wr_en); end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive_push(32'h3333, 5'd3, 1'b1);
    tick();
    drive_push(32'h4444, 5'd4, 1'b1);
    tick();
    drive_push(32'h8888, 5'd8, 1'b1);
    @(negedge clk);
    checks++; if (buf_count !== 2'd2) begin errors++; $display("[TB] FAIL bp_full_count got %0d exp 2", buf_count); end
    checks++; if (bus.ex_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ex_ready got %b exp 0", bus.ex_ready); end
    tick();
    @(negedge clk);
    checks++; if (buf_count !== 2'd2) begin errors++; $display("[TB] FAIL bp_refused got %0d exp 2", buf_count); end
    checks++; if (bus.rf_wr_addr !== 5'd3 || bus.rf_wr_data !== 32'h3333) begin errors++; $display("[TB] FAIL bp_hold got %0d/%h exp 3/3333", bus.rf_wr_addr, bus.rf_wr_data); end
    bus.rf_wr_ready = 1'b1;
    tick();
    bus.ex_valid = 1'b0;
    @(negedge clk);
    checks++; if (buf_count !== 2'd1) begin errors++; $display("[TB] FAIL bp_pop_no_push got %0d exp 1", buf_count); end
    checks++; if (bus.rf_wr_addr !== 5'd4 || bus.rf_wr_data !== 32'h4444) begin errors++; $display("[TB] FAIL bp_second got %0d/%h exp 4/4444", bus.rf_wr_addr, bus.rf_wr_data); end
    checks++; if (bus.ex_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_back got %b exp 1", bus.ex_ready); end
    tick();
    @(negedge clk);
    checks++; if (buf_count !== 2'd0 || bus.rf_wr_addr !== 5'd0) begin errors++; $display("[TB] FAIL bp_drained got %0d/%0d exp 0/0", buf_count, bus.rf_wr_addr); end
  endtask

  task automatic test_forwarding();
    do_reset();
    rs1_addr = 5'd7;
    rs2_addr = 5'd0;
    drive_push(32'hA, 5'd7, 1'b1);
    @(negedge clk);
    checks++; if (fwd1_hit !== 1'b0 || raw_stall !== 1'b0) begin errors++; $display("[TB] FAIL fwd_not_visible got %b%b exp 00", fwd1_hit, raw_stall); end
    tick();
    drive_push(32'hB, 5'd7, 1'b1);
    @(negedge clk);
    checks++; if (fwd1_hit !== FWD || fwd1_data !== (FWD ? 32'hA : 32'h0)) begin errors++; $display("[TB] FAIL fwd_first got %b/%h exp %b/%h", fwd1_hit, fwd1_data, FWD, FWD ? 32'hA : 32'h0); end
    tick();
    bus.ex_valid = 1'b0;
    @(negedge clk);
    checks++; if (fwd1_hit !== FWD || fwd1_data !== (FWD ? 32'hB : 32'h0)) begin errors++; $display("[TB] FAIL fwd_youngest got %b/%h exp %b/%h", fwd1_hit, fwd1_data, FWD, FWD ? 32'hB : 32'h0); end
    checks++; if (fwd2_hit !== 1'b0 || fwd2_data !== 32'h0) begin errors++; $display("[TB] FAIL fwd_rs_zero got %b/%h exp 0/0", fwd2_hit, fwd2_data); end
    checks++; if (raw_stall !== !FWD) begin errors++; $display("[TB] FAIL fwd_stall got %b exp %b", raw_stall, !FWD); end
    bus.rf_wr_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_div();
    int bad = 0;
    do_reset();
    bus.rf_wr_ready = 1'b1;
    drive_push(32'hFFFF_FFFF, 5'd9, 1'b1);
    bus.ex_is_div = 1'b1;
    bus.div_ready = 1'b0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      checks++; if (buf_count !== 2'd0 || bus.rf_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL div_wait cycle %0d got %0d/%b exp 0/0", i, buf_count, bus.rf_wr_en); end
      tick();
    end
    bus.div_ready = 1'b1;
    tick();
    drive_idle();
    bus.rf_wr_ready = 1'b1;
    @(negedge clk);
    checks++; if (buf_count !== 2'd1) begin errors++; $display("[TB] FAIL div_push got %0d exp 1", buf_count); end
    checks++; if (bus.rf_wr_addr !== 5'd9 || bus.rf_wr_data !== 32'hFFFF_FFFF || bus.rf_wr_en !== 1'b1) begin errors++; $display("[TB] FAIL div_result got %b/%0d/%h exp 1/9/ffffffff", bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data); end
    tick();
    @(negedge clk);
    checks++; if (buf_count !== 2'd0) begin errors++; $display("[TB] FAIL div_single got %0d exp 0", buf_count); end
    bad = bad;
  endtask

  task automatic test_rd_zero_and_stall();
    do_reset();
    drive_push(32'h55, 5'd0, 1'b1);
    tick();
    bus.ex_valid = 1'b0;
    @(negedge clk);
    checks++; if (buf_count !== 2'd1 || bus.rf_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL rd0_pending got %0d/%b exp 1/0", buf_count, bus.rf_wr_en); end
    tick();
    @(negedge clk);
    checks++; if (buf_count !== 2'd0) begin errors++; $display("[TB] FAIL rd0_retire got %0d exp 0", buf_count); end
    rs2_addr = 5'd6;
    drive_push(32'h66, 5'd6, 1'b1);
    tick();
    bus.ex_valid = 1'b0;
    @(negedge clk);
    checks++; if (raw_stall !== !FWD) begin errors++; $display("[TB] FAIL rd6_stall got %b exp %b", raw_stall, !FWD); end
    checks++; if (fwd2_hit !== FWD || fwd2_data !== (FWD ? 32'h66 : 32'h0)) begin errors++; $display("[TB] FAIL rd6_fwd got %b/%h exp %b/%h", fwd2_hit, fwd2_data, FWD, FWD ? 32'h66 : 32'h0); end
    tick();
    @(negedge clk);
    checks++; if (bus.rf_wr_en !== 1'b1 || bus.rf_wr_addr !== 5'd6 || buf_count !== 2'd1) begin errors++; $display("[TB] FAIL rd6_held got %b/%0d/%0d exp 1/6/1", bus.rf_wr_en, bus.rf_wr_addr, buf_count); end
    bus.rf_wr_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_push(32'h111, 5'd1, 1'b1);
    tick();
    drive_push(32'h222, 5'd2, 1'b1);
    tick();
    bus.ex_valid = 1'b0;
    @(negedge clk);
    checks++; if (buf_count !== 2'd2) begin errors++; $display("[TB] FAIL rmid_full got %0d exp 2", buf_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (buf_count !== 2'd0 || bus.ex_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_async got %0d/%b exp 0/1", buf_count, bus.ex_ready); end
    checks++; if (bus.rf_wr_en !== 1'b0 || bus.rf_wr_data !== 32'h0) begin errors++; $display("[TB] FAIL rmid_port got %b/%h exp 0/0", bus.rf_wr_en, bus.rf_wr_data); end
    mq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (buf_count !== 2'd0) begin errors++; $display("[TB] FAIL rmid_after got %0d exp 0", buf_count); end
  endtask

  task automatic test_random();
    bit                 h1, h2;
    logic [DATA_W-1:0]  d1, d2;
    bit                 e_wr_en;
    logic [RADDR_W-1:0] e_addr;
    logic [DATA_W-1:0]  e_data;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.ex_valid    = ($urandom_range(0, 9) < 6);
      bus.ex_is_div   = ($urandom_range(0, 3) == 0);
      bus.div_ready   = $urandom_range(0, 1) == 1;
      bus.ex_res      = $urandom;
      bus.ex_rd       = 5'($urandom_range(0, 7));
      bus.ex_we       = ($urandom_range(0, 3) != 0);
      bus.rf_wr_ready = ($urandom_range(0, 9) < 6);
      rs1_addr        = 5'($urandom_range(0, 7));
      rs2_addr        = 5'($urandom_range(0, 7));
      @(negedge clk);
      model_lookup(rs1_addr, h1, d1);
      model_lookup(rs2_addr, h2, d2);
      e_wr_en = (mq.size() > 0) && mq[0].we;
      e_addr  = (mq.size() > 0) ? mq[0].rd   : '0;
      e_data  = (mq.size() > 0) ? mq[0].data : '0;
      checks++; if (bus.ex_ready !== (mq.size() < 2)) begin errors++; $display("[TB] FAIL rand_ex_ready cyc %0d got %b exp %b", cyc, bus.ex_ready, mq.size() < 2); end
      checks++; if (buf_count !== 2'(mq.size())) begin errors++; $display("[TB] FAIL rand_count cyc %0d got %0d exp %0d", cyc, buf_count, mq.size()); end
      checks++; if (bus.rf_wr_en !== e_wr_en) begin errors++; $display("[TB] FAIL rand_wr_en cyc %0d got %b exp %b", cyc, bus.rf_wr_en, e_wr_en); end
      checks++; if (bus.rf_wr_addr !== e_addr) begin errors++; $display("[TB] FAIL rand_wr_addr cyc %0d got %0d exp %0d", cyc, bus.rf_wr_addr, e_addr); end
      checks++; if (bus.rf_wr_data !== e_data) begin errors++; $display("[TB] FAIL rand_wr_data cyc %0d got %h exp %h", cyc, bus.rf_wr_data, e_data); end
      checks++; if (fwd1_hit !== (FWD && h1)) begin errors++; $display("[TB] FAIL rand_fwd1_hit cyc %0d got %b exp %b", cyc, fwd1_hit, FWD && h1); end
      checks++; if (fwd1_data !== (FWD ? d1 : 32'h0)) begin errors++; $display("[TB] FAIL rand_fwd1_data cyc %0d got %h exp %h", cyc, fwd1_data, FWD ? d1 : 32'h0); end
      checks++; if (fwd2_hit !== (FWD && h2)) begin errors++; $display("[TB] FAIL rand_fwd2_hit cyc %0d got %b exp %b", cyc, fwd2_hit, FWD && h2); end
      checks++; if (fwd2_data !== (FWD ? d2 : 32'h0)) begin errors++; $display("[TB] FAIL rand_fwd2_data cyc %0d got %h exp %h", cyc, fwd2_data, FWD ? d2 : 32'h0); end
      checks++; if (raw_stall !== (!FWD && (h1 || h2))) begin errors++; $display("[TB] FAIL rand_stall cyc %0d got %b exp %b", cyc, raw_stall, !FWD && (h1 || h2)); end
      tick();
    end
  endtask

  initial begin
    drive_idle();
    $display("[TB] starting nanorv32_wb_buffer bench, forwarding build = %0d", FWD);
    test_reset();
    test_single_push();
    test_backpressure();
    test_forwarding();
    test_div();
    test_rd_zero_and_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
